// File: rtl/timer_unit.sv
// Memory-mapped cycle timer: free-running 32-bit counter, a programmable compare
// value and a sticky interrupt level that software clears with an acknowledge store.
module timer_unit #(
    parameter logic [31:0] CYCLE_ADDR = 32'hFFFF001C,
    parameter logic [31:0] CMP_ADDR   = 32'hFFFF0020,
    parameter logic [31:0] ACK_ADDR   = 32'hFFFF006C
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data,
    input  logic [31:0] address,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] cycle,
    output logic        TimerAddress,
    output logic        TimerInterrupt
);

    logic [31:0] r_cycle_count;
    logic [31:0] r_interrupt_cycle;
    logic        r_int_line;

    logic        w_hit_cycle;
    logic        w_hit_cmp;
    logic        w_hit_ack;
    logic        w_cmp_wr;
    logic        w_ack_wr;
    logic        w_match;
    logic [31:0] w_rdata;

    assign w_hit_cycle = (address == CYCLE_ADDR);
    assign w_hit_cmp   = (address == CMP_ADDR);
    assign w_hit_ack   = (address == ACK_ADDR);
    assign w_cmp_wr    = MemWrite && w_hit_cycle;
    assign w_ack_wr    = MemWrite && w_hit_ack;
    assign w_match     = (r_cycle_count == r_interrupt_cycle);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cycle_count     <= '0;
            r_interrupt_cycle <= '1;
            r_int_line        <= 1'b0;
        end else begin
            r_cycle_count <= r_cycle_count + 32'd1;
            if (w_cmp_wr)
                r_interrupt_cycle <= data;
            // Acknowledge takes priority over a match in the same cycle.
            if (w_ack_wr)
                r_int_line <= 1'b0;
            else if (w_match)
                r_int_line <= 1'b1;
        end
    end

    always_comb begin
        w_rdata = '0;
        if (!reset && MemRead) begin
            if (w_hit_cycle)
                w_rdata = r_cycle_count;
            else if (w_hit_cmp)
                w_rdata = r_interrupt_cycle;
        end
    end

    assign cycle          = w_rdata;
    assign TimerAddress   = w_hit_cycle || w_hit_cmp || w_hit_ack;
    assign TimerInterrupt = r_int_line;

endmodule

// File: tb/tb_timer_unit.sv
// Self-checking bench for timer_unit: directed scenarios plus random bus traffic,
// all compared against a cycle-level behavioural model of the timer.
`timescale 1ns/1ps
module tb_timer_unit;

    localparam logic [31:0] CYC = 32'hFFFF001C;
    localparam logic [31:0] CMP = 32'hFFFF0020;
    localparam logic [31:0] ACK = 32'hFFFF006C;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data = '0;
    logic [31:0] address = '0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] cycle;
    logic        TimerAddress;
    logic        TimerInterrupt;

    int unsigned checks = 0;
    int unsigned failures = 0;

    // Reference model: counter value, compare value, interrupt level
    logic [31:0] m_count;
    logic [31:0] m_cmp;
    logic        m_int;

    timer_unit #(.CYCLE_ADDR(CYC), .CMP_ADDR(CMP), .ACK_ADDR(ACK)) dut (
        .clock(clock), .reset(reset), .data(data), .address(address),
        .MemRead(MemRead), .MemWrite(MemWrite), .cycle(cycle),
        .TimerAddress(TimerAddress), .TimerInterrupt(TimerInterrupt)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_count = 32'd0;
        m_cmp   = 32'hFFFFFFFF;
        m_int   = 1'b0;
    endtask

    // One bus cycle: drive at negedge, check combinational outputs, then advance model at posedge.
    task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic rd, input logic wr);
        logic        exp_sel;
        logic [31:0] exp_rd;
        logic        nxt_int;
        @(negedge clock);
        address = a; data = d; MemRead = rd; MemWrite = wr;
        #1;
        exp_sel = (a == CYC) || (a == CMP) || (a == ACK);
        exp_rd  = !rd ? 32'd0 : (a == CYC) ? m_count : (a == CMP) ? m_cmp : 32'd0;
        check("taddr", {31'd0, TimerAddress}, {31'd0, exp_sel});
        check("rdata", cycle, exp_rd);
        check("irq", {31'd0, TimerInterrupt}, {31'd0, m_int});
        @(posedge clock);
        nxt_int = m_int || (m_count == m_cmp);
        if (wr && a == ACK) nxt_int = 1'b0;
        if (wr && a == CYC) m_cmp = d;
        m_count = m_count + 32'd1;
        m_int   = nxt_int;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) bus(CYC, 32'd0, 1'b1, 1'b0);
    endtask

    // Hold reset across a few edges, check outputs are 0, release just after an edge.
    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; address = CMP;
        #1;
        check("rst_rdata", cycle, 32'd0);
        check("rst_irq", {31'd0, TimerInterrupt}, 32'd0);
        check("rst_taddr", {31'd0, TimerAddress}, 32'd1);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();

        // Reset value: 5 edges then read both timer registers
        apply_reset();
        idle(5);
        bus(CYC, 32'd0, 1'b1, 1'b0);
        bus(CMP, 32'd0, 1'b1, 1'b0);

        // Basic fire: store 20 at count 3, watch rise at count 21 and hold
        apply_reset();
        idle(3);
        bus(CYC, 32'd20, 1'b0, 1'b1);
        idle(30);

        // Acknowledge, then no re-fire for 100 cycles
        bus(ACK, 32'hDEADBEEF, 1'b0, 1'b1);
        idle(100);

        // Ack coinciding with a match: acknowledge wins
        bus(CYC, m_count + 32'd3, 1'b0, 1'b1);
        idle(2);
        bus(ACK, 32'd0, 1'b0, 1'b1);
        idle(5);

        // Compare write colliding with a match of the old value: still fires
        bus(CYC, m_count + 32'd2, 1'b0, 1'b1);
        idle(1);
        bus(CYC, m_count + 32'd1000, 1'b0, 1'b1);
        idle(5);
        bus(ACK, 32'd0, 1'b0, 1'b1);

        // Compare equal to current count does not fire
        bus(CYC, m_count, 1'b0, 1'b1);
        idle(20);

        // Decode: near-miss addresses neither select nor store
        bus(32'hFFFF0018, m_count + 32'd2, 1'b1, 1'b1);
        bus(32'hFFFF001D, m_count + 32'd2, 1'b1, 1'b1);
        bus(CMP, 32'd7, 1'b1, 1'b1);
        idle(5);

        // Wrap: compare 0, jump counter near the top
        bus(CYC, 32'd0, 1'b0, 1'b1);
        #1 force dut.r_cycle_count = 32'hFFFFFFF0;
        #1 release dut.r_cycle_count;
        m_count = 32'hFFFFFFF0;
        idle(24);

        // Async reset pulse between edges while interrupt is high
        check("irq_before_pulse", {31'd0, TimerInterrupt}, 32'd1);
        address = CYC; MemRead = 1'b1; MemWrite = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("pulse_rdata", cycle, 32'd0);
        check("pulse_irq", {31'd0, TimerInterrupt}, 32'd0);
        #1 reset = 1'b0;
        #1;
        check("pulse_cnt", cycle, 32'd0);
        model_reset();
        idle(4);

        // Random traffic
        for (int unsigned i = 0; i < 3000; i++) begin
            int unsigned sel;
            logic [31:0] a;
            logic [31:0] d;
            logic        rd;
            logic        wr;
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2: a = CYC;
                3:       a = CMP;
                4:       a = ACK;
                5:       a = 32'hFFFF0018;
                6:       a = 32'hFFFF001D;
                default: a = $urandom;
            endcase
            rd = ($urandom_range(0, 1) == 1);
            wr = ($urandom_range(0, 3) == 0);
            d  = ($urandom_range(0, 7) == 0) ? $urandom : m_count + $urandom_range(0, 30);
            bus(a, d, rd, wr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
